// File: rtl/board_grid.sv
// board_grid: N x N game board with 2-bit cells, command/response port,
// and a one-cell-per-cycle scan that detects a run of K equal non-empty
// cells (horizontal, vertical, diagonal, anti-diagonal) or a full-board draw.
module board_grid #(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [$clog2(N)-1:0]         cmd_row,
   input  logic [$clog2(N)-1:0]         cmd_col,
   input  logic [1:0]                   cmd_data,
   output logic                         rsp_valid,
   output logic [1:0]                   rsp_data,
   output logic                         rsp_err,
   output logic                         game_end,
   output logic [1:0]                   winner,
   output logic [$clog2(N*N+1)-1:0]     move_count
);

   localparam int CELLS = N * N;
   localparam int RW    = $clog2(N);
   localparam int MCW   = $clog2(N * N + 1);
   localparam logic [MCW-1:0] MC_FULL = MCW'(CELLS);

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_CHECK = 2'b11;

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t                  state_q;
   logic [CELLS-1:0][1:0]   cells_q;
   logic [RW-1:0]           scan_r_q, scan_c_q;
   logic                    found_q;
   logic [1:0]              code_q;
   logic                    rsp_err_q;
   logic [1:0]              rsp_data_q;
   logic                    game_end_q;
   logic [1:0]              winner_q;
   logic [MCW-1:0]          mc_q;

   logic                    cmd_oob;
   int                      cmd_idx;
   logic [1:0]              cmd_cell;
   logic                    wr_reject;
   logic                    match;
   logic [1:0]              match_code;
   logic                    scan_last;

   // Cell lookup by row/col; callers guarantee the coordinate is on the board.
   function automatic logic [1:0] cell_at(input logic [CELLS-1:0][1:0] b,
                                          input int r, input int c);
      logic [1:0] v;
      v = 2'b00;
      for (int i = 0; i < CELLS; i++)
         if (i == r * N + c) v = b[i];
      return v;
   endfunction

   // Decode the command coordinates and decide whether a WRITE is legal.
   always_comb begin
      cmd_oob   = (int'(cmd_row) >= N) || (int'(cmd_col) >= N);
      cmd_idx   = int'(cmd_row) * N + int'(cmd_col);
      cmd_cell  = cmd_oob ? 2'b00 : cell_at(cells_q, int'(cmd_row), int'(cmd_col));
      wr_reject = cmd_oob || (cmd_data == 2'b00) || (cmd_data == 2'b11) ||
                  (cmd_cell != 2'b00) || game_end_q;
   end

   // Test the four run directions from the current scan cell, in priority order.
   always_comb begin
      int         sr, sc, dr, dc, rr, cc;
      logic       run_ok;
      logic [1:0] base;
      sr         = int'(scan_r_q);
      sc         = int'(scan_c_q);
      dr         = 0;
      dc         = 0;
      rr         = 0;
      cc         = 0;
      run_ok     = 1'b0;
      match      = 1'b0;
      match_code = 2'b00;
      base       = cell_at(cells_q, sr, sc);
      for (int d = 0; d < 4; d++) begin
         dr     = (d == 0) ? 0 : 1;
         dc     = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
         run_ok = (base != 2'b00);
         for (int k = 1; k < K; k++) begin
            rr = sr + k * dr;
            cc = sc + k * dc;
            if (rr < 0 || rr >= N || cc < 0 || cc >= N) run_ok = 1'b0;
            else if (cell_at(cells_q, rr, cc) != base)  run_ok = 1'b0;
         end
         if (run_ok && !match) begin
            match      = 1'b1;
            match_code = base;
         end
      end
      scan_last = (scan_r_q == RW'(N - 1)) && (scan_c_q == RW'(N - 1));
   end

   // Command FSM: board updates at acceptance, one-cycle response in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cells_q    <= '0;
         scan_r_q   <= '0;
         scan_c_q   <= '0;
         found_q    <= 1'b0;
         code_q     <= 2'b00;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= 2'b00;
         game_end_q <= 1'b0;
         winner_q   <= 2'b00;
         mc_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rsp_err_q  <= 1'b0;
               rsp_data_q <= 2'b00;
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_CLEAR: begin
                        cells_q    <= '0;
                        game_end_q <= 1'b0;
                        winner_q   <= 2'b00;
                        mc_q       <= '0;
                        state_q    <= RESP;
                     end
                     OP_WRITE: begin
                        if (wr_reject) begin
                           rsp_err_q <= 1'b1;
                        end else begin
                           for (int i = 0; i < CELLS; i++)
                              if (i == cmd_idx) cells_q[i] <= cmd_data;
                           if (mc_q != MC_FULL) mc_q <= mc_q + MCW'(1);
                        end
                        state_q <= RESP;
                     end
                     OP_READ: begin
                        rsp_data_q <= cmd_cell;
                        rsp_err_q  <= cmd_oob;
                        state_q    <= RESP;
                     end
                     default: begin
                        scan_r_q <= '0;
                        scan_c_q <= '0;
                        found_q  <= 1'b0;
                        code_q   <= 2'b00;
                        state_q  <= SCAN;
                     end
                  endcase
               end
            end
            SCAN: begin
               // first match wins; later matches are ignored
               if (match && !found_q) begin
                  found_q <= 1'b1;
                  code_q  <= match_code;
               end
               if (scan_c_q == RW'(N - 1)) begin
                  scan_c_q <= '0;
                  scan_r_q <= scan_r_q + RW'(1);
               end else begin
                  scan_c_q <= scan_c_q + RW'(1);
               end
               if (scan_last) begin
                  state_q <= RESP;
                  if (found_q) begin
                     game_end_q <= 1'b1;
                     winner_q   <= code_q;
                  end else if (match) begin
                     game_end_q <= 1'b1;
                     winner_q   <= match_code;
                  end else begin
                     game_end_q <= (mc_q == MC_FULL);
                     winner_q   <= 2'b00;
                  end
               end
            end
            RESP: begin
               rsp_err_q  <= 1'b0;
               rsp_data_q <= 2'b00;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign game_end   = game_end_q;
   assign winner     = winner_q;
   assign move_count = mc_q;

endmodule

// File: tb/tb_board_grid.sv
// Scoreboard bench for board_grid: one N=3/K=3 instance and one N=5/K=4
// instance share the command bus; cmd_sel routes cmd_valid to one of them.
module tb_board_grid;

   localparam logic [1:0] OP_CLR = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_CHK = 2'b11;
   localparam logic [1:0] A = 2'b01, B = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_sel = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_row = 3'd0, cmd_col = 3'd0;
   logic [1:0] cmd_data = 2'b00;

   logic       rdy3, vld3, err3, ge3;
   logic [1:0] dat3, win3;
   logic [3:0] mc3;
   logic       rdy5, vld5, err5, ge5;
   logic [1:0] dat5, win5;
   logic [4:0] mc5;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] data;
      logic       err;
      int         lat;
      logic       ge;
      logic [1:0] win;
      int         mc;
      int         acc;
   } exp_t;

   exp_t q3[$];
   exp_t q5[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   board_grid #(.N(3), .K(3)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~cmd_sel), .cmd_ready(rdy3),
      .cmd_op(cmd_op), .cmd_row(cmd_row[1:0]), .cmd_col(cmd_col[1:0]), .cmd_data(cmd_data),
      .rsp_valid(vld3), .rsp_data(dat3), .rsp_err(err3),
      .game_end(ge3), .winner(win3), .move_count(mc3)
   );

   board_grid #(.N(5), .K(4)) dut5 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid & cmd_sel), .cmd_ready(rdy5),
      .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
      .rsp_valid(vld5), .rsp_data(dat5), .rsp_err(err5),
      .game_end(ge5), .winner(win5), .move_count(mc5)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor for the N=3 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst && vld3) begin
         if (q3.size() == 0) begin
            chk("dut3 unexpected rsp_valid", 1, 0);
         end else begin
            e = q3.pop_front();
            chk("dut3 rsp_data",   int'(dat3), int'(e.data));
            chk("dut3 rsp_err",    int'(err3), int'(e.err));
            chk("dut3 latency",    cyc + 1 - e.acc, e.lat);
            chk("dut3 game_end",   int'(ge3), int'(e.ge));
            chk("dut3 winner",     int'(win3), int'(e.win));
            chk("dut3 move_count", int'(mc3), e.mc);
         end
      end
   end

   // monitor for the N=5 instance
   always @(negedge clk) begin
      exp_t e;
      if (!rst && vld5) begin
         if (q5.size() == 0) begin
            chk("dut5 unexpected rsp_valid", 1, 0);
         end else begin
            e = q5.pop_front();
            chk("dut5 rsp_data",   int'(dat5), int'(e.data));
            chk("dut5 rsp_err",    int'(err5), int'(e.err));
            chk("dut5 latency",    cyc + 1 - e.acc, e.lat);
            chk("dut5 game_end",   int'(ge5), int'(e.ge));
            chk("dut5 winner",     int'(win5), int'(e.win));
            chk("dut5 move_count", int'(mc5), e.mc);
         end
      end
   end

   task automatic issue(input bit s5, input logic [1:0] op, input int r, input int c,
                        input logic [1:0] d, input bit want, input logic [1:0] edata,
                        input bit eerr, input int elat, input bit ege,
                        input logic [1:0] ewin, input int emc);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clk);
      while (!(s5 ? rdy5 : rdy3) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         chk("cmd_ready timeout", 0, 1);
         return;
      end
      cmd_sel   = s5;
      cmd_op    = op;
      cmd_row   = 3'(r);
      cmd_col   = 3'(c);
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      e.data = edata; e.err = eerr; e.lat = elat; e.ge = ege;
      e.win = ewin; e.mc = emc; e.acc = cyc;
      if (want) begin
         if (s5) q5.push_back(e);
         else    q3.push_back(e);
      end
   endtask

   task automatic wr(input bit s5, input int r, input int c, input logic [1:0] d,
                     input bit err, input int mc, input bit ge, input logic [1:0] win);
      issue(s5, OP_WR, r, c, d, 1'b1, 2'b00, err, 1, ge, win, mc);
   endtask

   task automatic rd(input bit s5, input int r, input int c, input logic [1:0] data,
                     input bit err, input int mc, input bit ge, input logic [1:0] win);
      issue(s5, OP_RD, r, c, 2'b00, 1'b1, data, err, 1, ge, win, mc);
   endtask

   task automatic clr(input bit s5);
      issue(s5, OP_CLR, 0, 0, 2'b00, 1'b1, 2'b00, 1'b0, 1, 1'b0, 2'b00, 0);
   endtask

   task automatic check_board(input bit s5, input bit ge, input logic [1:0] win, input int mc);
      issue(s5, OP_CHK, 0, 0, 2'b00, 1'b1, 2'b00, 1'b0, s5 ? 26 : 10, ge, win, mc);
   endtask

   logic [1:0] draw_pat [9] = '{A, B, A,
                                A, B, B,
                                B, A, A};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset cmd_ready",  int'(rdy3), 1);
      chk("reset rsp_valid",  int'(vld3), 0);
      chk("reset game_end",   int'(ge3),  0);
      chk("reset winner",     int'(win3), 0);
      chk("reset move_count", int'(mc3),  0);
      chk("reset dut5 ready", int'(rdy5), 1);

      // horizontal win on top row
      wr(0, 0, 0, A, 0, 1, 0, 2'b00);
      wr(0, 0, 1, A, 0, 2, 0, 2'b00);
      wr(0, 0, 2, A, 0, 3, 0, 2'b00);
      check_board(0, 1, A, 3);
      wr(0, 1, 1, B, 1, 3, 1, A);          // rejected: game already over
      clr(0);

      // occupied-cell rejection
      wr(0, 1, 1, B, 0, 1, 0, 2'b00);
      wr(0, 1, 1, A, 1, 1, 0, 2'b00);
      rd(0, 1, 1, B, 0, 1, 0, 2'b00);
      check_board(0, 0, 2'b00, 1);         // no result, board not full

      // illegal coordinates and codes
      wr(0, 3, 0, A,     1, 1, 0, 2'b00);
      wr(0, 0, 0, 2'b11, 1, 1, 0, 2'b00);
      wr(0, 0, 0, 2'b00, 1, 1, 0, 2'b00);
      rd(0, 0, 3, 2'b00, 1, 1, 0, 2'b00);
      rd(0, 0, 0, 2'b00, 0, 1, 0, 2'b00);

      // full board with no run -> draw
      clr(0);
      for (int i = 0; i < 9; i++) wr(0, i / 3, i % 3, draw_pat[i], 0, i + 1, 0, 2'b00);
      check_board(0, 1, 2'b00, 9);
      wr(0, 0, 0, A, 1, 9, 1, 2'b00);
      rd(0, 2, 1, A, 0, 9, 1, 2'b00);

      // two runs present: raster-first (row 0, A) wins
      clr(0);
      for (int c = 0; c < 3; c++) wr(0, 2, c, B, 0, c + 1, 0, 2'b00);
      for (int c = 0; c < 3; c++) wr(0, 0, c, A, 0, c + 4, 0, 2'b00);
      check_board(0, 1, A, 6);

      // vertical win
      clr(0);
      for (int r = 0; r < 3; r++) wr(0, r, 1, B, 0, r + 1, 0, 2'b00);
      check_board(0, 1, B, 3);

      // diagonal win
      clr(0);
      for (int r = 0; r < 3; r++) wr(0, r, r, A, 0, r + 1, 0, 2'b00);
      check_board(0, 1, A, 3);

      // N=5, K=4: three-long runs do not count, four-long anti-diagonal does
      wr(1, 0, 4, B, 0, 1, 0, 2'b00);
      wr(1, 1, 3, B, 0, 2, 0, 2'b00);
      wr(1, 2, 2, B, 0, 3, 0, 2'b00);
      wr(1, 4, 0, A, 0, 4, 0, 2'b00);
      wr(1, 4, 1, A, 0, 5, 0, 2'b00);
      wr(1, 4, 2, A, 0, 6, 0, 2'b00);
      check_board(1, 0, 2'b00, 6);
      wr(1, 3, 1, B, 0, 7, 0, 2'b00);
      check_board(1, 1, B, 7);
      clr(1);
      rd(1, 2, 2, 2'b00, 0, 0, 0, 2'b00);
      rd(1, 5, 0, 2'b00, 1, 0, 0, 2'b00);

      // reset in the middle of a scan: no response, board cleared
      clr(0);
      wr(0, 0, 0, A, 0, 1, 0, 2'b00);
      wr(0, 2, 2, B, 0, 2, 0, 2'b00);
      t = 0;
      while ((q3.size() != 0 || q5.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      issue(0, OP_CHK, 0, 0, 2'b00, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b00, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort cmd_ready",  int'(rdy3), 1);
      chk("abort rsp_valid",  int'(vld3), 0);
      chk("abort move_count", int'(mc3),  0);
      repeat (12) @(negedge clk);           // any late rsp_valid is caught by the monitor
      for (int i = 0; i < 9; i++) rd(0, i / 3, i % 3, 2'b00, 0, 0, 0, 2'b00);

      t = 0;
      while ((q3.size() != 0 || q5.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("dut3 responses outstanding", q3.size(), 0);
      chk("dut5 responses outstanding", q5.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_grid.md
BOARD_GRID -- requirements
Module: board_grid

Interface
REQ-001 Parameter N, default 3: board side length; legal range 3..8.
REQ-002 Parameter K, default 3: win run length; legal range 3..N.
REQ-003 Cell encoding is fixed at 2 bits: 00 empty, 01 player A, 10 player B, 11 reserved.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-008 cmd_op  input  2  operation: 00 CLEAR, 01 WRITE, 10 READ, 11 CHECK.
REQ-009 cmd_row, cmd_col  input  clog2(N) each  cell coordinates.
REQ-010 cmd_data  input  2  cell value for WRITE.
REQ-011 rsp_valid  output  1  one-cycle pulse that completes each accepted command.
REQ-012 rsp_data  output  2  READ result; 00 for all other ops.
REQ-013 rsp_err  output  1  command rejected; qualified by rsp_valid.
REQ-014 game_end  output  1  win or draw detected by the last CHECK.
REQ-015 winner  output  2  winning player code; 00 means draw or no result.
REQ-016 move_count  output  clog2(N*N+1)  number of successful WRITEs since the last CLEAR.

Function
REQ-017 A command is accepted on a rising edge where cmd_valid and cmd_ready are both high.
REQ-018 The FSM has states IDLE, SCAN and RESP; CLEAR, WRITE and READ go IDLE->RESP->IDLE; CHECK goes IDLE->SCAN->RESP->IDLE.
REQ-019 rsp_valid is high for exactly one cycle, in RESP.
REQ-020 CLEAR sets all N*N cells to 00 at acceptance and zeroes game_end, winner and move_count; rsp_err=0.
REQ-021 WRITE is rejected with rsp_err=1 and no state change if any of these holds: row or col >= N; cmd_data is 00 or 11; the target cell is non-empty; game_end=1.
REQ-022 An accepted, non-rejected WRITE stores cmd_data into the cell at acceptance and increments move_count; rsp_err=0.
REQ-023 READ returns the cell value on rsp_data during RESP; an out-of-range coordinate returns 00 with rsp_err=1.
REQ-024 CHECK scans start cells in raster order, one cell per cycle, for N*N cycles.
REQ-025 For each start cell, CHECK evaluates four directions in priority order: horizontal, vertical, diagonal, anti-diagonal.
REQ-026 A run matches when all K cells lie on the board, are equal to each other and are non-empty.
REQ-027 On the first match, CHECK latches winner=matching code and game_end=1; later matches are ignored; the scan always runs the full N*N cycles.
REQ-028 If no match is found and move_count==N*N, CHECK sets game_end=1 and winner=00 (draw).
REQ-029 If no match is found and the board is not full, CHECK leaves game_end=0 and winner=00.
REQ-030 CHECK latency is exactly N*N+1 cycles from acceptance to rsp_valid.
REQ-031 CLEAR, WRITE and READ latency is exactly 1 cycle from acceptance to rsp_valid.
REQ-032 Board cells are written only by CLEAR and WRITE; no other command modifies the board.
REQ-033 cmd_* inputs are ignored while cmd_ready=0.
REQ-034 game_end and winner hold their values until CLEAR or rst.
REQ-035 move_count saturates at N*N.

Reset
REQ-036 rst, sampled on a rising edge, forces the following regardless of state: FSM to IDLE, all cells to 00, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=00, game_end=0, winner=00, move_count=0.
REQ-037 rst asserted during SCAN aborts the scan and produces no rsp_valid; rst has priority over any simultaneous command.

Verification
REQ-038 N=3, K=3: WRITE 01 to (0,0),(0,1),(0,2), then CHECK -> rsp_valid exactly 10 cycles after CHECK acceptance, game_end=1, winner=01.
REQ-039 N=3: WRITE 10 to (1,1), then WRITE 01 to (1,1) -> second response has rsp_err=1, READ (1,1) returns 10, move_count=1.
REQ-040 N=3: fill all 9 cells in a no-win pattern, then CHECK -> game_end=1, winner=00, move_count=9; a further WRITE returns rsp_err=1.
REQ-041 N=5, K=4: WRITE 10 on anti-diagonal (0,4),(1,3),(2,2),(3,1), then CHECK -> winner=10 after 26 cycles; CLEAR -> game_end=0, move_count=0, READ (2,2) returns 00.
REQ-042 N=3: assert rst in cycle 4 of a CHECK scan -> no rsp_valid, cmd_ready=1 on the next cycle, all cells read back as 00.
REQ-043 WRITE with row=3 on N=3, and WRITE with cmd_data=11 -> both return rsp_err=1 and move_count is unchanged.
